// File: rtl/screen_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : screen_pkg
// Purpose  : Shared definitions for the screen sequencer. Holds the state
//            codes, the state width and the number of selectable screens.
// Revision : 1.0 - initial release
// ============================================================================
package screen_pkg;

    localparam int STATE_W     = 3;
    localparam int NUM_SCREENS = 5;

    // State codes double as the per-screen VGA stream index.
    localparam logic [STATE_W-1:0] START = 3'd0;
    localparam logic [STATE_W-1:0] PLAY  = 3'd1;
    localparam logic [STATE_W-1:0] PAUSE = 3'd2;
    localparam logic [STATE_W-1:0] LOSE  = 3'd3;
    localparam logic [STATE_W-1:0] WIN   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/screen_sequencer_key_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_edge
// Purpose  : Rising-edge detector for a keyboard level.
//            The delayed copy resets to 1, so a key that is already held
//            when reset releases gives no edge until it is released and
//            pressed again.
// Ports    : clk    - system clock
//            reset  - synchronous, active-high
//            i_key  - key level
//            o_rise - one-cycle pulse on a 0->1 transition of i_key
// Revision : 1.0 - initial release
// ============================================================================
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_key,
    output logic o_rise
);

    logic r_key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_q <= 1'b1;
        end else begin
            r_key_q <= i_key;
        end
    end

    assign o_rise = i_key & ~r_key_q;

endmodule
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : screen_sequencer
// Purpose  : Game/screen controller. Runs the START/PLAY/PAUSE/LOSE/WIN flow
//            from edge-detected keys and the moles-screen win/lose levels,
//            optionally times result screens back to START, and registers
//            the VGA stream of the current screen onto the outputs.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            key_space/esc/pause   - keyboard levels
//            win, lose             - levels from the moles screen
//            scr_hsync/vsync       - per-screen syncs, bit index = state code
//            scr_red/green/blue    - packed per-screen colours
//            hsync/vsync/red/green/blue - registered selected VGA stream
//            state                 - current state code
//            play_en               - high while in PLAY
//            play_clear            - one-cycle pulse on a fresh entry to PLAY
// Revision : 1.0 - initial release
// ============================================================================
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int COLOR_W        = 4,
    parameter int RESULT_TIMEOUT = 0,
    parameter int PAUSE_EN       = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           key_space,
    input  logic                           key_esc,
    input  logic                           key_pause,
    input  logic                           win,
    input  logic                           lose,
    input  logic [NUM_SCREENS-1:0]         scr_hsync,
    input  logic [NUM_SCREENS-1:0]         scr_vsync,
    input  logic [NUM_SCREENS*COLOR_W-1:0] scr_red,
    input  logic [NUM_SCREENS*COLOR_W-1:0] scr_green,
    input  logic [NUM_SCREENS*COLOR_W-1:0] scr_blue,
    output logic                           hsync,
    output logic                           vsync,
    output logic [COLOR_W-1:0]             red,
    output logic [COLOR_W-1:0]             green,
    output logic [COLOR_W-1:0]             blue,
    output logic [STATE_W-1:0]             state,
    output logic                           play_en,
    output logic                           play_clear
);

    // Counter only has to reach RESULT_TIMEOUT-1; keep at least one bit.
    localparam int CNT_W = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT + 1) : 1;

    logic               w_space_rise;
    logic               w_esc_rise;
    logic               w_pause_rise;
    logic               w_pause_ok;
    logic               w_timeout;
    logic               w_fresh_play;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_play_clear;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sel_hsync;
    logic               w_sel_vsync;
    logic [COLOR_W-1:0] w_sel_red;
    logic [COLOR_W-1:0] w_sel_green;
    logic [COLOR_W-1:0] w_sel_blue;

    logic               r_hsync;
    logic               r_vsync;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    // ------------------------------------------------------------------
    // Key edge detectors
    // ------------------------------------------------------------------
    key_edge u_space_edge (
        .clk    (clk),
        .reset  (reset),
        .i_key  (key_space),
        .o_rise (w_space_rise)
    );

    key_edge u_esc_edge (
        .clk    (clk),
        .reset  (reset),
        .i_key  (key_esc),
        .o_rise (w_esc_rise)
    );

    key_edge u_pause_edge (
        .clk    (clk),
        .reset  (reset),
        .i_key  (key_pause),
        .o_rise (w_pause_rise)
    );

    assign w_pause_ok = (PAUSE_EN != 0);

    // ------------------------------------------------------------------
    // Result-screen timeout
    // ------------------------------------------------------------------
    generate
        if (RESULT_TIMEOUT != 0) begin : g_timeout_on
            assign w_timeout = (r_cnt == CNT_W'(RESULT_TIMEOUT - 1));
        end else begin : g_timeout_off
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // play_clear is registered with the state so it is high in exactly
    // the first cycle that state reads PLAY after a fresh start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= START;
            r_play_clear <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_play_clear <= w_fresh_play;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (priority follows if/else order)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            START: begin
                if (w_space_rise) w_next_state = PLAY;
            end
            PLAY: begin
                if (win)                             w_next_state = WIN;
                else if (lose)                       w_next_state = LOSE;
                else if (w_esc_rise)                 w_next_state = START;
                else if (w_pause_rise && w_pause_ok) w_next_state = PAUSE;
            end
            PAUSE: begin
                if (w_esc_rise)                        w_next_state = START;
                else if (w_pause_rise || w_space_rise) w_next_state = PLAY;
            end
            LOSE, WIN: begin
                if (w_esc_rise)        w_next_state = START;
                else if (w_space_rise) w_next_state = PLAY;
                else if (w_timeout)    w_next_state = START;
            end
            default: w_next_state = START;
        endcase
    end

    // Resuming from PAUSE keeps the board; every other entry clears it.
    assign w_fresh_play = (w_next_state == PLAY) &&
                          ((r_state == START) || (r_state == LOSE) || (r_state == WIN));

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        play_en    = (r_state == PLAY);
        play_clear = r_play_clear;
    end

    assign state = r_state;

    // ------------------------------------------------------------------
    // Timeout counter: runs only while a result screen is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == LOSE) || (r_state == WIN)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // VGA stream select; illegal codes fall through to screen 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_hsync = scr_hsync[0];
        w_sel_vsync = scr_vsync[0];
        w_sel_red   = scr_red[COLOR_W-1:0];
        w_sel_green = scr_green[COLOR_W-1:0];
        w_sel_blue  = scr_blue[COLOR_W-1:0];
        for (int i = 1; i < NUM_SCREENS; i++) begin
            if (r_state == STATE_W'(i)) begin
                w_sel_hsync = scr_hsync[i];
                w_sel_vsync = scr_vsync[i];
                w_sel_red   = scr_red[i*COLOR_W +: COLOR_W];
                w_sel_green = scr_green[i*COLOR_W +: COLOR_W];
                w_sel_blue  = scr_blue[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hsync <= w_sel_hsync;
            r_vsync <= w_sel_vsync;
            r_red   <= w_sel_red;
            r_green <= w_sel_green;
            r_blue  <= w_sel_blue;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign red   = r_red;
    assign green = r_green;
    assign blue  = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_sequencer
// Purpose  : Directed self-checking bench for screen_sequencer. A second
//            instance with the pause state disabled shares all stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

    localparam int COLOR_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_space, key_esc, key_pause, win, lose;
    logic [4:0]  scr_hsync, scr_vsync;
    logic [19:0] scr_red, scr_green, scr_blue;

    logic        hsync, vsync, play_en, play_clear;
    logic [3:0]  red, green, blue;
    logic [2:0]  state;

    logic        np_hsync, np_vsync, np_play_en, np_play_clear;
    logic [3:0]  np_red, np_green, np_blue;
    logic [2:0]  np_state;

    integer checks = 0;
    integer errors = 0;

    screen_sequencer #(.COLOR_W(COLOR_W), .RESULT_TIMEOUT(8), .PAUSE_EN(1)) dut (
        .clk(clk), .reset(reset), .key_space(key_space), .key_esc(key_esc),
        .key_pause(key_pause), .win(win), .lose(lose),
        .scr_hsync(scr_hsync), .scr_vsync(scr_vsync),
        .scr_red(scr_red), .scr_green(scr_green), .scr_blue(scr_blue),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .state(state), .play_en(play_en), .play_clear(play_clear)
    );

    screen_sequencer #(.COLOR_W(COLOR_W), .RESULT_TIMEOUT(8), .PAUSE_EN(0)) dut_np (
        .clk(clk), .reset(reset), .key_space(key_space), .key_esc(key_esc),
        .key_pause(key_pause), .win(win), .lose(lose),
        .scr_hsync(scr_hsync), .scr_vsync(scr_vsync),
        .scr_red(scr_red), .scr_green(scr_green), .scr_blue(scr_blue),
        .hsync(np_hsync), .vsync(np_vsync), .red(np_red), .green(np_green),
        .blue(np_blue), .state(np_state), .play_en(np_play_en),
        .play_clear(np_play_clear)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic press_space;
        key_space = 1'b1; step(); key_space = 1'b0;
    endtask

    task automatic press_esc;
        key_esc = 1'b1; step(); key_esc = 1'b0;
    endtask

    task automatic press_pause;
        key_pause = 1'b1; step(); key_pause = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; key_space = 1'b1;
        step(); step();
        checks++; if (state !== 3'd0)  begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (play_en !== 1'b0) begin errors++; $display("FAIL reset_play_en got %b exp 0", play_en); end
        checks++; if (play_clear !== 1'b0) begin errors++; $display("FAIL reset_play_clear got %b exp 0", play_clear); end
        checks++; if ({hsync, vsync} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", {hsync, vsync}); end
        checks++; if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {red, green, blue}); end
    endtask

    task automatic test_held_key;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_space_state cyc %0d got %0d exp 0", i, state); end
        end
        key_space = 1'b0; step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL released_state got %0d exp 0", state); end
        key_space = 1'b1; step();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL press_state got %0d exp 1", state); end
        checks++; if (play_clear !== 1'b1) begin errors++; $display("FAIL press_clear got %b exp 1", play_clear); end
        checks++; if (play_en !== 1'b1) begin errors++; $display("FAIL press_play_en got %b exp 1", play_en); end
        key_space = 1'b0; step();
        checks++; if (play_clear !== 1'b0) begin errors++; $display("FAIL clear_width got %b exp 0", play_clear); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL play_hold got %0d exp 1", state); end
    endtask

    task automatic test_win_beats_lose;
        win = 1'b1; lose = 1'b1; step(); win = 1'b0; lose = 1'b0;
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL win_priority got %0d exp 4", state); end
        checks++; if (play_en !== 1'b0) begin errors++; $display("FAIL win_play_en got %b exp 0", play_en); end
    endtask

    task automatic test_win_esc_space;
        key_esc = 1'b1; key_space = 1'b1; step(); key_esc = 1'b0; key_space = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL esc_over_space got %0d exp 0", state); end
        checks++; if (play_clear !== 1'b0) begin errors++; $display("FAIL esc_clear got %b exp 0", play_clear); end
        step();
    endtask

    task automatic test_lose_timeout;
        press_space();
        lose = 1'b1; step(); lose = 1'b0;
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL lose_enter got %0d exp 3", state); end
        for (int k = 1; k < 8; k++) begin
            step();
            checks++; if (state !== 3'd3 || play_clear !== 1'b0) begin
                errors++; $display("FAIL lose_hold k=%0d got state %0d clr %b exp 3 0", k, state, play_clear);
            end
            if (k == 1) begin
                checks++; if (red !== 4'hD) begin errors++; $display("FAIL lose_red got %h exp d", red); end
            end
        end
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL lose_timeout got %0d exp 0", state); end
        checks++; if (play_clear !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", play_clear); end
    endtask

    task automatic test_pause;
        press_space();
        press_pause();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_state got %0d exp 2", state); end
        checks++; if (play_en !== 1'b0) begin errors++; $display("FAIL pause_play_en got %b exp 0", play_en); end
        checks++; if (np_state !== 3'd1) begin errors++; $display("FAIL nopause_state got %0d exp 1", np_state); end
        checks++; if (np_play_en !== 1'b1) begin errors++; $display("FAIL nopause_play_en got %b exp 1", np_play_en); end
        step();
        press_space();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
        checks++; if (play_clear !== 1'b0) begin errors++; $display("FAIL resume_clear got %b exp 0", play_clear); end
        checks++; if (np_state !== 3'd1) begin errors++; $display("FAIL nopause_space got %0d exp 1", np_state); end
    endtask

    task automatic test_vga_mux;
        // In PLAY
        step();
        checks++; if (red !== 4'hB || hsync !== 1'b0 || green !== 4'h2) begin
            errors++; $display("FAIL mux_play got r%h h%b g%h exp rb h0 g2", red, hsync, green);
        end
        press_pause(); step();
        checks++; if (red !== 4'hC || hsync !== 1'b1) begin
            errors++; $display("FAIL mux_pause got r%h h%b exp rc h1", red, hsync);
        end
        press_esc(); step();
        checks++; if (red !== 4'hA || hsync !== 1'b1 || vsync !== 1'b0) begin
            errors++; $display("FAIL mux_start got r%h h%b v%b exp ra h1 v0", red, hsync, vsync);
        end
        scr_red = 20'hEDCB7; step();
        checks++; if (red !== 4'h7) begin errors++; $display("FAIL mux_latency got %h exp 7", red); end
        scr_red = 20'hEDCBA; step();
        press_space();
        lose = 1'b1; step(); lose = 1'b0; step();
        checks++; if (red !== 4'hD || hsync !== 1'b1 || blue !== 4'h8) begin
            errors++; $display("FAIL mux_lose got r%h h%b b%h exp rd h1 b8", red, hsync, blue);
        end
        press_esc();
        press_space(); step();
        win = 1'b1; step(); win = 1'b0;
        checks++; if (state !== 3'd4 || red !== 4'hB) begin
            errors++; $display("FAIL mux_switch_delay got s%0d r%h exp s4 rb", state, red);
        end
        step();
        checks++; if (red !== 4'hE || hsync !== 1'b0 || vsync !== 1'b1 || blue !== 4'h9) begin
            errors++; $display("FAIL mux_win got r%h h%b v%b b%h exp re h0 v1 b9", red, hsync, vsync, blue);
        end
    endtask

    task automatic test_reset_mid_win;
        reset = 1'b1; step();
        checks++; if (state !== 3'd0 || red !== 4'h0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL mid_reset got s%0d r%h h%b v%b exp s0 r0 h1 v1", state, red, hsync, vsync);
        end
        checks++; if (play_en !== 1'b0) begin errors++; $display("FAIL mid_reset_play_en got %b exp 0", play_en); end
        reset = 1'b0; step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset got %0d exp 0", state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; key_space = 1'b0; key_esc = 1'b0; key_pause = 1'b0;
        win = 1'b0; lose = 1'b0;
        scr_hsync = 5'b01101;
        scr_vsync = 5'b10010;
        scr_red   = 20'hEDCBA;
        scr_green = 20'h54321;
        scr_blue  = 20'h98765;

        test_reset();
        test_held_key();
        test_win_beats_lose();
        test_win_esc_space();
        test_lose_timeout();
        test_pause();
        test_vga_mux();
        test_reset_mid_win();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
